vx_unified_sets_ctrl: RTL and testbench
=======================================

// Module: vx_unified_sets_ctrl
// PURPOSE
// - Sits directly upstream of the socket's dcache cluster. It owns the unified_cache_sets value that the cluster
//   uses to split each bank between L1 sets and shared-memory sets.
// - Captures shared-memory set counts written over the DCR bus and clamps them.
// - Before the new L1/shared split takes effect: stalls core dcache requests, drains in-flight requests,
//   then invalidates every set whose role changes. A live split change therefore never aliases stale lines.
// PARAMETERS
// - TOTAL_SETS      64      cache sets per bank (DCACHE_SIZE/WAYS/BANKS/LINE)
// - SETS_WIDTH      12      width of set-count values
// - NUM_REQS        4       dcache request lanes observed for in-flight counting
// - MAX_PENDING     64      max in-flight requests; counter width CLOG2(MAX_PENDING+1)
// - DCR_ADDR_WIDTH  12      DCR address width
// - DCR_DATA_WIDTH  32      DCR data width
// - SETS_DCR_ADDR   12'h00A DCR address of the shared-memory set count
// PORTS
// - clk              in   1               clock; single clock domain
// - reset_n          in   1               asynchronous, active-low reset
// - dcr_write_valid  in   1               DCR write strobe
// - dcr_write_addr   in   DCR_ADDR_WIDTH  DCR write address
// - dcr_write_data   in   DCR_DATA_WIDTH  DCR write data; bits [SETS_WIDTH-1:0] = requested shared-memory sets
// - req_fire         in   NUM_REQS        per-lane core->dcache request handshake (valid&ready)
// - rsp_fire         in   NUM_REQS        per-lane dcache->core response handshake
// - req_stall        out  1               registered; upstream gates all req_valid while high
// - inval_valid      out  1               invalidate request for set inval_set (all banks, all ways)
// - inval_set        out  SETS_WIDTH      set index to invalidate
// - inval_ready      in   1               cache accepted invalidate
// - l1_sets          out  SETS_WIDTH      sets used as L1; drives cluster unified_cache_sets
// - busy             out  1               high whenever state != IDLE or a change is pending
// BEHAVIOUR
// - Reset values: l1_sets=TOTAL_SETS, req_stall=0, inval_valid=0, inval_set=0, busy=0.
//   Internal reset values: outstanding=0, pending_valid=0, state=IDLE.
// - Capture: dcr_write_valid && addr==SETS_DCR_ADDR ->
//     sm = min(data[SETS_WIDTH-1:0], TOTAL_SETS-1);
//     target = TOTAL_SETS - sm, so at least 1 L1 set always remains;
//     pending <= target, pending_valid <= 1 in the next cycle.
//   Writes in any state overwrite pending (latest wins). A write arriving during a transition is applied after
//   the return to IDLE. Other DCR addresses are ignored.
// - Outstanding counter: next = cur + popcount(req_fire) - popcount(rsp_fire). Simultaneous inc and dec net
//   in the same cycle.
// - Assertions: underflow; exceeding MAX_PENDING; any req_fire while req_stall=1 is illegal.
// - FSM:
//   - IDLE: pending_valid && pending==l1_sets -> clear pending_valid, stay IDLE.
//     pending_valid && pending!=l1_sets -> latch new=pending, clear pending_valid -> STALL.
//   - STALL (req_stall=1 from this cycle on): one cycle for in-flight handshakes to settle -> DRAIN.
//   - DRAIN: wait until outstanding==0 -> INVAL, with inval_set=min(l1_sets,new).
//   - INVAL: inval_valid=1. On inval_valid&&inval_ready: inval_set++. The handshake on set
//     max(l1_sets,new)-1 -> APPLY. inval_set must hold stable while inval_ready=0.
//   - APPLY: l1_sets<=new -> IDLE. req_stall drops in the IDLE cycle.
// - Latency: DCR write in cycle t, outstanding=0, inval_ready tied 1, N=|new-old|:
//   req_stall rises t+2, l1_sets changes at the edge ending t+4+N, req_stall low t+5+N.
// - Shrinking L1 and growing L1 both invalidate exactly the N set indices whose role flips.
// - reset_n asserted mid-transition: immediate return to the reset values; the pending write is lost.
// CONFIGURATION
// - VX_SETS_CTRL_PERF_EN defined: adds outputs
//     perf_reconfigs [31:0]  count of APPLY entries
//     perf_stall_cycles [43:0]  cycles with req_stall=1
//   Both reset to 0 and saturate at all-ones.
// - Undefined: neither port nor counter logic exists. Functional behaviour is identical in both builds.
// TESTING
// - Reset, no DCR writes:
//   -> l1_sets=64, req_stall=0, busy=0, inval_valid never asserted.
// - Write sm=16, idle traffic, inval_ready=1:
//   -> inval sets 48..63 in order, l1_sets=48 at t+4+16, req_stall low t+21.
// - Write sm=200 (above max):
//   -> clamped to 63, l1_sets=1, sets 1..63 invalidated.
// - Write sm=16 with 5 requests in flight, responses spread over 20 cycles:
//   -> no inval_valid until outstanding reaches 0; zero req_fire while stalled.
// - During INVAL, write sm=8 and toggle inval_ready randomly:
//   -> inval_set holds while not ready; first change completes, then a second transition to l1_sets=56.
// - Write sm=16, then assert reset_n=0 mid-DRAIN:
//   -> l1_sets=64, req_stall=0, busy=0 after reset.
//   With VX_SETS_CTRL_PERF_EN, after the second test: perf_reconfigs=1, perf_stall_cycles=19.

Source files
------------

// File: rtl/vx_unified_sets_ctrl_if.sv
// Bundles the DCR write bus, the dcache handshake observations and the invalidate channel of vx_unified_sets_ctrl.
// The master side is the socket environment and the slave side is the controller.
interface vx_unified_sets_ctrl_if #(
  parameter int SETS_WIDTH     = 12,
  parameter int NUM_REQS       = 4,
  parameter int DCR_ADDR_WIDTH = 12,
  parameter int DCR_DATA_WIDTH = 32
);
  logic                      dcr_write_valid;
  logic [DCR_ADDR_WIDTH-1:0] dcr_write_addr;
  logic [DCR_DATA_WIDTH-1:0] dcr_write_data;
  logic [NUM_REQS-1:0]       req_fire;
  logic [NUM_REQS-1:0]       rsp_fire;
  logic                      req_stall;
  logic                      inval_valid;
  logic [SETS_WIDTH-1:0]     inval_set;
  logic                      inval_ready;
  logic [SETS_WIDTH-1:0]     l1_sets;
  logic                      busy;

  modport master (
    output dcr_write_valid, dcr_write_addr, dcr_write_data,
    output req_fire, rsp_fire, inval_ready,
    input  req_stall, inval_valid, inval_set, l1_sets, busy
  );

  modport slave (
    input  dcr_write_valid, dcr_write_addr, dcr_write_data,
    input  req_fire, rsp_fire, inval_ready,
    output req_stall, inval_valid, inval_set, l1_sets, busy
  );
endinterface

// File: rtl/vx_unified_sets_ctrl.sv
// Owns the dcache L1/shared-memory set split: stalls and drains the core, invalidates re-roled sets, then applies it.
// Optional macro VX_SETS_CTRL_PERF_EN adds saturating reconfiguration and stall-cycle counters.
module vx_unified_sets_ctrl #(
  parameter int TOTAL_SETS     = 64,
  parameter int SETS_WIDTH     = 12,
  parameter int NUM_REQS       = 4,
  parameter int MAX_PENDING    = 64,
  parameter int DCR_ADDR_WIDTH = 12,
  parameter int DCR_DATA_WIDTH = 32,
  parameter logic [DCR_ADDR_WIDTH-1:0] SETS_DCR_ADDR = 12'h00A
) (
  input  logic clk,
  input  logic reset_n,
  vx_unified_sets_ctrl_if.slave bus
`ifdef VX_SETS_CTRL_PERF_EN
  ,
  output logic [31:0] perf_reconfigs,
  output logic [43:0] perf_stall_cycles
`endif
);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [SETS_WIDTH-1:0] TOTAL  = SETS_WIDTH'(TOTAL_SETS);
  localparam logic [SETS_WIDTH-1:0] MAX_SM = SETS_WIDTH'(TOTAL_SETS - 1);

  typedef enum logic [2:0] {IDLE, STALL, DRAIN, INVAL, APPLY} state_e;

  state_e                state_q, state_d;
  logic [SETS_WIDTH-1:0] l1_sets_q, l1_sets_d;
  logic [SETS_WIDTH-1:0] new_sets_q, new_sets_d;
  logic [SETS_WIDTH-1:0] pending_q, pending_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [SETS_WIDTH-1:0] inval_set_q, inval_set_d;
  logic                  req_stall_q, req_stall_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;

  logic [CNT_W:0]        req_cnt, rsp_cnt, cnt_sum;
  logic                  cnt_underflow, cnt_overflow;
  logic [SETS_WIDTH-1:0] sm_req, sm_clamped, inval_first, inval_last;
  logic                  dcr_hit;

  always_comb begin
    req_cnt = '0;
    rsp_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      req_cnt = req_cnt + (CNT_W+1)'(bus.req_fire[i]);
      rsp_cnt = rsp_cnt + (CNT_W+1)'(bus.rsp_fire[i]);
    end
    cnt_sum       = {1'b0, outstanding_q} + req_cnt - rsp_cnt;
    cnt_underflow = ({1'b0, outstanding_q} + req_cnt) < rsp_cnt;
    cnt_overflow  = !cnt_underflow && (cnt_sum > (CNT_W+1)'(MAX_PENDING));
    outstanding_d = cnt_sum[CNT_W-1:0];
  end

  always_comb begin
    sm_req      = bus.dcr_write_data[SETS_WIDTH-1:0];
    sm_clamped  = (sm_req > MAX_SM) ? MAX_SM : sm_req;
    dcr_hit     = bus.dcr_write_valid && (bus.dcr_write_addr == SETS_DCR_ADDR);
    inval_first = (l1_sets_q < new_sets_q) ? l1_sets_q : new_sets_q;
    inval_last  = ((l1_sets_q > new_sets_q) ? l1_sets_q : new_sets_q) - SETS_WIDTH'(1);
  end

  always_comb begin
    state_d         = state_q;
    l1_sets_d       = l1_sets_q;
    new_sets_d      = new_sets_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    inval_set_d     = inval_set_q;
    case (state_q)
      IDLE: begin
        if (pending_valid_q) begin
          pending_valid_d = 1'b0;
          if (pending_q != l1_sets_q) begin
            new_sets_d = pending_q;
            state_d    = STALL;
          end
        end
      end
      STALL: state_d = DRAIN;
      DRAIN: begin
        if (outstanding_q == '0) begin
          inval_set_d = inval_first;
          state_d     = INVAL;
        end
      end
      INVAL: begin
        if (bus.inval_ready) begin
          inval_set_d = inval_set_q + SETS_WIDTH'(1);
          if (inval_set_q == inval_last) state_d = APPLY;
        end
      end
      APPLY: begin
        l1_sets_d = new_sets_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh write overrides whatever the FSM just consumed, so the latest value always wins.
    if (dcr_hit) begin
      pending_d       = TOTAL - sm_clamped;
      pending_valid_d = 1'b1;
    end
    req_stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      l1_sets_q       <= TOTAL;
      new_sets_q      <= TOTAL;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      inval_set_q     <= '0;
      req_stall_q     <= 1'b0;
      outstanding_q   <= '0;
    end else begin
      state_q         <= state_d;
      l1_sets_q       <= l1_sets_d;
      new_sets_q      <= new_sets_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      inval_set_q     <= inval_set_d;
      req_stall_q     <= req_stall_d;
      outstanding_q   <= outstanding_d;
    end
  end

  assign bus.req_stall   = req_stall_q;
  assign bus.inval_valid = (state_q == INVAL);
  assign bus.inval_set   = inval_set_q;
  assign bus.l1_sets     = l1_sets_q;
  assign bus.busy        = (state_q != IDLE) || pending_valid_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !cnt_underflow);
  a_no_overflow:  assert property (@(posedge clk) disable iff (!reset_n) !cnt_overflow);
  a_no_req_while_stalled: assert property (@(posedge clk) disable iff (!reset_n)
    !(req_stall_q && (|bus.req_fire)));

`ifdef VX_SETS_CTRL_PERF_EN
  logic [31:0] perf_reconfigs_q, perf_reconfigs_d;
  logic [43:0] perf_stall_cycles_q, perf_stall_cycles_d;

  always_comb begin
    perf_reconfigs_d    = perf_reconfigs_q;
    perf_stall_cycles_d = perf_stall_cycles_q;
    if ((state_q == APPLY) && (perf_reconfigs_q != '1)) perf_reconfigs_d = perf_reconfigs_q + 32'd1;
    if (req_stall_q && (perf_stall_cycles_q != '1)) perf_stall_cycles_d = perf_stall_cycles_q + 44'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_reconfigs_q    <= '0;
      perf_stall_cycles_q <= '0;
    end else begin
      perf_reconfigs_q    <= perf_reconfigs_d;
      perf_stall_cycles_q <= perf_stall_cycles_d;
    end
  end

  assign perf_reconfigs    = perf_reconfigs_q;
  assign perf_stall_cycles = perf_stall_cycles_q;
`endif
endmodule

// File: tb/tb_vx_unified_sets_ctrl.sv
// Directed self-checking bench for vx_unified_sets_ctrl; inputs are driven and outputs sampled on the falling edge.
module tb_vx_unified_sets_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vx_unified_sets_ctrl_if bus_if ();

`ifdef VX_SETS_CTRL_PERF_EN
  logic [31:0] perf_reconfigs;
  logic [43:0] perf_stall_cycles;
`endif

  vx_unified_sets_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
`ifdef VX_SETS_CTRL_PERF_EN
    ,
    .perf_reconfigs    (perf_reconfigs),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  task automatic clear_inputs();
    bus_if.dcr_write_valid = 1'b0;
    bus_if.dcr_write_addr  = '0;
    bus_if.dcr_write_data  = '0;
    bus_if.req_fire        = '0;
    bus_if.rsp_fire        = '0;
    bus_if.inval_ready     = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one write in the current cycle and returns at the falling edge of the following cycle.
  task automatic dcr_write(input logic [11:0] addr, input logic [31:0] data);
    bus_if.dcr_write_valid = 1'b1;
    bus_if.dcr_write_addr  = addr;
    bus_if.dcr_write_data  = data;
    @(negedge clk);
    bus_if.dcr_write_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic seen_inval;
    do_reset();
    checks++; if (bus_if.l1_sets !== 12'd64) begin failures++; $display("[TB] FAIL reset_l1 got=%0d exp=64", bus_if.l1_sets); end
    checks++; if (bus_if.req_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b exp=0", bus_if.req_stall); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", bus_if.busy); end
    checks++; if (bus_if.inval_set !== 12'd0) begin failures++; $display("[TB] FAIL reset_inval_set got=%0d exp=0", bus_if.inval_set); end
    seen_inval = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.inval_valid !== 1'b0) seen_inval = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen_inval !== 1'b0) begin failures++; $display("[TB] FAIL reset_no_inval got=%0b exp=0", seen_inval); end
    checks++; if (bus_if.l1_sets !== 12'd64) begin failures++; $display("[TB] FAIL reset_l1_hold got=%0d exp=64", bus_if.l1_sets); end
  endtask

  task automatic test_shrink();
    logic exp_stall, exp_inv, exp_busy;
    logic [11:0] exp_l1, exp_set;
    do_reset();
    dcr_write(12'h00A, 32'd16);
    for (int k = 1; k <= 22; k++) begin
      exp_stall = (k >= 2 && k <= 20);
      exp_inv   = (k >= 4 && k <= 19);
      exp_busy  = (k <= 20);
      exp_l1    = (k >= 21) ? 12'd48 : 12'd64;
      exp_set   = 12'(44 + k);
      checks++; if (bus_if.req_stall !== exp_stall) begin failures++; $display("[TB] FAIL shrink_stall k=%0d got=%0b exp=%0b", k, bus_if.req_stall, exp_stall); end
      checks++; if (bus_if.inval_valid !== exp_inv) begin failures++; $display("[TB] FAIL shrink_inval_valid k=%0d got=%0b exp=%0b", k, bus_if.inval_valid, exp_inv); end
      checks++; if (bus_if.busy !== exp_busy) begin failures++; $display("[TB] FAIL shrink_busy k=%0d got=%0b exp=%0b", k, bus_if.busy, exp_busy); end
      checks++; if (bus_if.l1_sets !== exp_l1) begin failures++; $display("[TB] FAIL shrink_l1 k=%0d got=%0d exp=%0d", k, bus_if.l1_sets, exp_l1); end
      if (exp_inv) begin
        checks++; if (bus_if.inval_set !== exp_set) begin failures++; $display("[TB] FAIL shrink_inval_set k=%0d got=%0d exp=%0d", k, bus_if.inval_set, exp_set); end
      end
      @(negedge clk);
    end
`ifdef VX_SETS_CTRL_PERF_EN
    checks++; if (perf_reconfigs !== 32'd1) begin failures++; $display("[TB] FAIL perf_reconfigs got=%0d exp=1", perf_reconfigs); end
    checks++; if (perf_stall_cycles !== 44'd19) begin failures++; $display("[TB] FAIL perf_stall_cycles got=%0d exp=19", perf_stall_cycles); end
`endif
  endtask

  task automatic test_no_change();
    logic seen_stall;
    dcr_write(12'h00B, 32'd8);
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL other_addr_busy got=%0b exp=0", bus_if.busy); end
    dcr_write(12'h00A, 32'd16);
    checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("[TB] FAIL same_value_pending got=%0b exp=1", bus_if.busy); end
    seen_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus_if.req_stall !== 1'b0) seen_stall = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen_stall !== 1'b0) begin failures++; $display("[TB] FAIL same_value_stall got=%0b exp=0", seen_stall); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL same_value_busy got=%0b exp=0", bus_if.busy); end
    checks++; if (bus_if.l1_sets !== 12'd48) begin failures++; $display("[TB] FAIL same_value_l1 got=%0d exp=48", bus_if.l1_sets); end
  endtask

  task automatic test_clamp();
    int exp_set;
    int cyc;
    do_reset();
    dcr_write(12'h00A, 32'd200);
    exp_set = 1;
    cyc = 0;
    while (bus_if.busy === 1'b1 && cyc < 300) begin
      if (bus_if.inval_valid === 1'b1) begin
        checks++; if (bus_if.inval_set !== 12'(exp_set)) begin failures++; $display("[TB] FAIL clamp_inval_set got=%0d exp=%0d", bus_if.inval_set, exp_set); end
        exp_set++;
      end
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc >= 300) begin failures++; $display("[TB] FAIL clamp_timeout got=%0d exp<300", cyc); end
    checks++; if (exp_set != 64) begin failures++; $display("[TB] FAIL clamp_inval_count got=%0d exp=63", exp_set - 1); end
    checks++; if (bus_if.l1_sets !== 12'd1) begin failures++; $display("[TB] FAIL clamp_l1 got=%0d exp=1", bus_if.l1_sets); end
  endtask

  task automatic test_in_flight();
    int outstanding;
    int first_inval;
    int c;
    do_reset();
    bus_if.req_fire = 4'b0111;
    @(negedge clk);
    bus_if.req_fire = 4'b0011;
    @(negedge clk);
    bus_if.req_fire = 4'b0000;
    outstanding = 5;
    dcr_write(12'h00A, 32'd16);
    first_inval = -1;
    c = 1;
    while ((c < 24 || bus_if.busy === 1'b1) && c < 100) begin
      if (bus_if.inval_valid === 1'b1 && first_inval < 0) first_inval = c;
      if (bus_if.inval_valid === 1'b1 && outstanding != 0) begin
        checks++; failures++;
        $display("[TB] FAIL inflight_early_inval c=%0d got_outstanding=%0d exp=0", c, outstanding);
      end
      if (c >= 2 && c <= 21) begin
        checks++; if (bus_if.req_stall !== 1'b1) begin failures++; $display("[TB] FAIL inflight_stall c=%0d got=%0b exp=1", c, bus_if.req_stall); end
      end
      bus_if.rsp_fire = (c % 4 == 0 && c <= 20) ? 4'b0001 : 4'b0000;
      if (bus_if.rsp_fire != 4'b0000) outstanding--;
      c++;
      @(negedge clk);
    end
    bus_if.rsp_fire = '0;
    checks++; if (first_inval != 22) begin failures++; $display("[TB] FAIL inflight_first_inval got=%0d exp=22", first_inval); end
    checks++; if (bus_if.l1_sets !== 12'd48) begin failures++; $display("[TB] FAIL inflight_l1 got=%0d exp=48", bus_if.l1_sets); end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int hs;
    logic wrote, saw48, rdy;
    int cyc;
    do_reset();
    for (int s = 48; s < 64; s++) exp_q.push_back(s);
    for (int s = 48; s < 56; s++) exp_q.push_back(s);
    dcr_write(12'h00A, 32'd16);
    hs = 0; wrote = 1'b0; saw48 = 1'b0; cyc = 0;
    while (!(exp_q.size() == 0 && bus_if.busy === 1'b0) && cyc < 400) begin
      bus_if.dcr_write_valid = 1'b0;
      if (bus_if.l1_sets === 12'd48) saw48 = 1'b1;
      rdy = 1'($urandom_range(0, 1));
      bus_if.inval_ready = rdy;
      if (bus_if.inval_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL b2b_extra_inval got=%0d exp=none", bus_if.inval_set);
        end else begin
          checks++; if (bus_if.inval_set !== 12'(exp_q[0])) begin failures++; $display("[TB] FAIL b2b_inval_set got=%0d exp=%0d", bus_if.inval_set, exp_q[0]); end
          if (rdy) begin
            void'(exp_q.pop_front());
            hs++;
          end
        end
      end
      if (hs == 5 && !wrote) begin
        bus_if.dcr_write_valid = 1'b1;
        bus_if.dcr_write_addr  = 12'h00A;
        bus_if.dcr_write_data  = 32'd8;
        wrote = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    bus_if.dcr_write_valid = 1'b0;
    bus_if.inval_ready = 1'b1;
    checks++; if (cyc >= 400) begin failures++; $display("[TB] FAIL b2b_timeout got=%0d exp<400", cyc); end
    checks++; if (saw48 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_apply got=%0b exp=1", saw48); end
    checks++; if (hs != 24) begin failures++; $display("[TB] FAIL b2b_handshakes got=%0d exp=24", hs); end
    checks++; if (bus_if.l1_sets !== 12'd56) begin failures++; $display("[TB] FAIL b2b_l1 got=%0d exp=56", bus_if.l1_sets); end
  endtask

  task automatic test_reset_mid_drain();
    logic bad;
    do_reset();
    bus_if.req_fire = 4'b0011;
    @(negedge clk);
    bus_if.req_fire = 4'b0000;
    dcr_write(12'h00A, 32'd16);
    repeat (2) @(negedge clk);
    checks++; if (bus_if.req_stall !== 1'b1) begin failures++; $display("[TB] FAIL drain_stall got=%0b exp=1", bus_if.req_stall); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus_if.l1_sets !== 12'd64) begin failures++; $display("[TB] FAIL midreset_l1 got=%0d exp=64", bus_if.l1_sets); end
    checks++; if (bus_if.req_stall !== 1'b0) begin failures++; $display("[TB] FAIL midreset_stall got=%0b exp=0", bus_if.req_stall); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%0b exp=0", bus_if.busy); end
    checks++; if (bus_if.inval_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_inval got=%0b exp=0", bus_if.inval_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.busy !== 1'b0 || bus_if.req_stall !== 1'b0 || bus_if.l1_sets !== 12'd64) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("[TB] FAIL postreset_quiet got=%0b exp=0", bad); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_shrink();
    test_no_change();
    test_clamp();
    test_in_flight();
    test_back_to_back();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
